// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and data bundle for the serial subtractor: the requester drives start and
// the operands, and the subtractor returns status, the result and the cell's bit view.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             x;
    logic             y;

    modport master (
        output start, a_in, b_in,
        input  busy, done, diff, borrow_out, x, y
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, diff, borrow_out, x, y
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor computing A - B LSB first through one full-subtractor cell.
// The difference shifts back into A, so A holds the parallel result once done pulses.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    serial_subtractor_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               x_bit;
    logic               y_bit;
    logic               d_bit;
    logic               bo_bit;

    // The cell always looks at the low bits of both shift registers.
    assign x_bit  = a_q[0];
    assign y_bit  = b_q[0];
    assign d_bit  = x_bit ^ y_bit ^ borrow_q;
    assign bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a_in;
                    b_d      = bus.b_in;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d      = {d_bit, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = bo_bit;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last of exactly WIDTH shift edges.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.diff       = a_q;
    assign bus.borrow_out = borrow_q;
    assign bus.x          = x_bit;
    assign bus.y          = y_bit;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: a 4-bit instance for directed scenarios and an
// 8-bit instance for a random sweep, both compared every cycle to an arithmetic model.
module tb_serial_subtractor_ctrl;
    localparam int W4 = 4;
    localparam int W8 = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(W4)) bus4 ();
    serial_subtractor_ctrl_if #(.WIDTH(W8)) bus8 ();

    serial_subtractor_ctrl #(.WIDTH(W4), .CNT_W(4)) u4 (.clk(clk), .rstn(rstn), .bus(bus4.slave));
    serial_subtractor_ctrl #(.WIDTH(W8), .CNT_W(4)) u8 (.clk(clk), .rstn(rstn), .bus(bus8.slave));

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // After s of w shifts, the top s bits of A hold the low s bits of a-b and the
    // bottom w-s bits hold the not-yet-consumed minuend bits.
    function automatic int exp_diff(int w, int a, int b, int s);
        int m;
        m = (1 << s) - 1;
        return ((((a - b) & m) << (w - s)) | (a >> s)) & ((1 << w) - 1);
    endfunction

    function automatic int exp_borrow(int a, int b, int s);
        int m;
        m = (1 << s) - 1;
        return ((a & m) < (b & m)) ? 1 : 0;
    endfunction

    // Model: act = operation in progress, s = shifts performed so far.
    int act4 = 0, s4 = W4, a4 = 0, b4 = 0;
    int act8 = 0, s8 = W8, a8 = 0, b8 = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act4 <= 0; s4 <= W4; a4 <= 0; b4 <= 0;
        end else if (act4 == 0) begin
            if (bus4.start) begin
                act4 <= 1; s4 <= 0; a4 <= int'(bus4.a_in); b4 <= int'(bus4.b_in);
            end
        end else if (s4 < W4) begin
            s4 <= s4 + 1;
        end else begin
            act4 <= 0;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act8 <= 0; s8 <= W8; a8 <= 0; b8 <= 0;
        end else if (act8 == 0) begin
            if (bus8.start) begin
                act8 <= 1; s8 <= 0; a8 <= int'(bus8.a_in); b8 <= int'(bus8.b_in);
            end
        end else if (s8 < W8) begin
            s8 <= s8 + 1;
        end else begin
            act8 <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m4_busy",   32'(bus4.busy),       32'(act4));
            chk("m4_done",   32'(bus4.done),       32'((act4 != 0) && (s4 == W4)));
            chk("m4_diff",   32'(bus4.diff),       32'(exp_diff(W4, a4, b4, s4)));
            chk("m4_borrow", 32'(bus4.borrow_out), 32'(exp_borrow(a4, b4, s4)));
            chk("m4_x",      32'(bus4.x),          32'(exp_diff(W4, a4, b4, s4) & 1));
            chk("m4_y",      32'(bus4.y),          32'((b4 >> s4) & 1));
            chk("m8_busy",   32'(bus8.busy),       32'(act8));
            chk("m8_done",   32'(bus8.done),       32'((act8 != 0) && (s8 == W8)));
            chk("m8_diff",   32'(bus8.diff),       32'(exp_diff(W8, a8, b8, s8)));
            chk("m8_borrow", 32'(bus8.borrow_out), 32'(exp_borrow(a8, b8, s8)));
            chk("m8_x",      32'(bus8.x),          32'(exp_diff(W8, a8, b8, s8) & 1));
            chk("m8_y",      32'(bus8.y),          32'((b8 >> s8) & 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Counts edges after the accepting edge until done is seen, bounded.
    task automatic wait_done(input int which, output int edges);
        edges = 0;
        while (((which == 4) ? bus4.done : bus8.done) !== 1'b1 && edges < 30) begin
            step();
            edges++;
        end
        if (edges >= 30) chk("done_timeout", 32'(edges), 32'd0);
    endtask

    task automatic show4(input string tag, input int a, input int b);
        $display("op%s a=%0d b=%0d diff=%0h borrow=%0d", tag, a, b, bus4.diff, bus4.borrow_out);
    endtask

    initial begin
        int edges;
        int ndone;
        int sv_diff;
        int sv_borrow;
        int pa[3];
        int pb[3];
        int ed[3];
        int eb[3];
        logic [3:0] xs;
        logic [3:0] ys;

        bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0;

        // Reset
        #1 rstn = 1'b0;
        #1 cmp_en = 1'b1;
        #10;
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_diff", 32'(bus4.diff), 32'd0);
        chk("rst_borrow", 32'(bus4.borrow_out), 32'd0);
        step();
        rstn = 1'b1;
        step();

        // 9 - 3
        bus4.start = 1'b1; bus4.a_in = 4'd9; bus4.b_in = 4'd3;
        step();
        bus4.start = 1'b0;
        chk("t1_busy_rise", 32'(bus4.busy), 32'd1);
        wait_done(4, edges);
        chk("t1_latency", 32'(edges + 1), 32'd5);
        chk("t1_diff", 32'(bus4.diff), 32'd6);
        chk("t1_borrow", 32'(bus4.borrow_out), 32'd0);
        show4("_9m3", 9, 3);
        step();
        chk("t1_done_one_cycle", 32'(bus4.done), 32'd0);

        // 3 - 9 with per-shift x/y
        xs = 4'b0011; ys = 4'b1001;
        bus4.start = 1'b1; bus4.a_in = 4'd3; bus4.b_in = 4'd9;
        step();
        bus4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_x", 32'(bus4.x), 32'(xs[i]));
            chk("t2_y", 32'(bus4.y), 32'(ys[i]));
            step();
        end
        chk("t2_done", 32'(bus4.done), 32'd1);
        chk("t2_diff", 32'(bus4.diff), 32'hA);
        chk("t2_borrow", 32'(bus4.borrow_out), 32'd1);
        show4("_3m9", 3, 9);
        step();

        // Back to back with start held high
        pa = '{5, 0, 15}; pb = '{5, 1, 0};
        ed = '{0, 15, 15}; eb = '{0, 1, 0};
        bus4.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus4.a_in = 4'(pa[k]); bus4.b_in = 4'(pb[k]);
            step();
            chk("t3_busy_accept", 32'(bus4.busy), 32'd1);
            if (k < 2) begin
                bus4.a_in = 4'(pa[k+1]); bus4.b_in = 4'(pb[k+1]);
            end
            wait_done(4, edges);
            chk("t3_diff", 32'(bus4.diff), 32'(ed[k]));
            chk("t3_borrow", 32'(bus4.borrow_out), 32'(eb[k]));
            show4("_b2b", pa[k], pb[k]);
            if (k == 2) bus4.start = 1'b0;
            step();
            chk("t3_idle_gap", 32'(bus4.busy), 32'd0);
        end
        step();

        // Start pulses while busy are ignored
        bus4.start = 1'b1; bus4.a_in = 4'd10; bus4.b_in = 4'd4;
        step();
        bus4.start = 1'b0;
        ndone = 0; sv_diff = -1; sv_borrow = -1;
        for (int i = 1; i <= 10; i++) begin
            if (bus4.done) begin
                ndone++; sv_diff = int'(bus4.diff); sv_borrow = int'(bus4.borrow_out);
            end
            bus4.start = (i == 2 || i == 5);
            bus4.a_in = 4'd1; bus4.b_in = 4'd15;
            step();
        end
        bus4.start = 1'b0;
        chk("t4_done_count", 32'(ndone), 32'd1);
        chk("t4_diff", 32'(sv_diff), 32'd6);
        chk("t4_borrow", 32'(sv_borrow), 32'd0);
        chk("t4_idle_after", 32'(bus4.busy), 32'd0);
        $display("op_ignore a=10 b=4 dones=%0d diff=%0h", ndone, sv_diff);

        // Asynchronous reset during the third shift
        bus4.start = 1'b1; bus4.a_in = 4'd9; bus4.b_in = 4'd3;
        step();
        bus4.start = 1'b0;
        step();
        step();
        #1 rstn = 1'b0;
        #1;
        chk("t5_busy", 32'(bus4.busy), 32'd0);
        chk("t5_done", 32'(bus4.done), 32'd0);
        chk("t5_diff", 32'(bus4.diff), 32'd0);
        chk("t5_borrow", 32'(bus4.borrow_out), 32'd0);
        chk("t5_xy", 32'({bus4.x, bus4.y}), 32'd0);
        step();
        chk("t5_no_done", 32'(bus4.done), 32'd0);
        rstn = 1'b1;
        step();
        bus4.start = 1'b1; bus4.a_in = 4'd12; bus4.b_in = 4'd7;
        step();
        bus4.start = 1'b0;
        wait_done(4, edges);
        chk("t5_diff_after", 32'(bus4.diff), 32'd5);
        chk("t5_borrow_after", 32'(bus4.borrow_out), 32'd0);
        show4("_12m7", 12, 7);
        step();

        // Random sweep on the 8-bit instance
        for (int n = 0; n < 200; n++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            bus8.start = 1'b1; bus8.a_in = 8'(a); bus8.b_in = 8'(b);
            step();
            bus8.start = 1'b0;
            bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom);
            wait_done(8, edges);
            chk("r8_latency", 32'(edges + 1), 32'd9);
            chk("r8_diff", 32'(bus8.diff), 32'((a - b) & 8'hFF));
            chk("r8_borrow", 32'(bus8.borrow_out), 32'(a < b));
            $display("rand%0d a=%0d b=%0d diff=%0h borrow=%0d", n, a, b, bus8.diff, bus8.borrow_out);
            step();
        end

        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
